// File: rtl/inj_sched.sv
// Injection scheduler for one torus router node.
// Round-robin arbitration among N_SRC local clients feeds a DEPTH-entry FIFO.
// The FIFO head goes to the routing stage and is popped on i_ack. The block
// also counts popped flits and flags a head that has waited too long.
module inj_sched #(
    parameter int X_W        = 2,
    parameter int Y_W        = 2,
    parameter int D_W        = 8,
    parameter int N_SRC      = 2,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_SRC-1:0]       src_v,
    input  logic [N_SRC*X_W-1:0]   src_x,
    input  logic [N_SRC*Y_W-1:0]   src_y,
    input  logic [N_SRC*D_W-1:0]   src_d,
    output logic [N_SRC-1:0]       src_rdy,
    output logic [X_W-1:0]         i_x,
    output logic [Y_W-1:0]         i_y,
    output logic [D_W-1:0]         i_d,
    output logic                   i_v,
    input  logic                   i_ack,
    output logic                   starve,
    output logic [15:0]            inj_cnt
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int RW  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int SW  = $clog2(STARVE_MAX + 1);
    localparam int E_W = X_W + Y_W + D_W;

    // Each FIFO entry holds {x, y, d}
    logic [E_W-1:0]   mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [RW-1:0]    rr_ptr;
    logic [SW-1:0]    stall;

    logic             full;
    logic             push;
    logic             pop;
    logic             gnt_any;
    logic [RW-1:0]    gnt_idx;
    logic [N_SRC-1:0] gnt_oh;
    logic [E_W-1:0]   wdata;
    logic [E_W-1:0]   head;
    int               idx;

    assign full = (count == CW'(DEPTH));
    assign i_v  = (count != '0);
    assign pop  = i_v && i_ack;

    // Round-robin search starting at rr_ptr; picks the first requesting client
    always_comb begin
        // NOTE: every signal gets a default before the loop so no latch is inferred.
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        wdata   = '0;
        idx     = 0;
        for (int i = 0; i < N_SRC; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_SRC)
                idx = idx - N_SRC;
            if (!gnt_any && src_v[idx]) begin
                gnt_any     = 1'b1;
                gnt_idx     = RW'(idx);
                gnt_oh[idx] = 1'b1;
                wdata       = {src_x[idx*X_W +: X_W],
                               src_y[idx*Y_W +: Y_W],
                               src_d[idx*D_W +: D_W]};
            end
        end
    end

    // The grant uses the registered full flag, so a pop never frees a slot
    // for a push in the same cycle. While reset is asserted no grant is shown.
    assign push    = gnt_any && !full && rst_n;
    assign src_rdy = push ? gnt_oh : '0;

    // FIFO storage write
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count gates every read.
        if (push)
            mem[wr_ptr] <= wdata;
    end

    // Pointers, occupancy and arbitration pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (gnt_idx == RW'(N_SRC - 1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= gnt_idx + RW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Popped-flit counter, wraps at 2^16
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inj_cnt <= '0;
        else if (pop)
            inj_cnt <= inj_cnt + 16'd1;
    end

    // Consecutive-stall counter, saturating at STARVE_MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall <= '0;
        else if (!i_v || i_ack)
            stall <= '0;
        else if (stall != SW'(STARVE_MAX))
            stall <= stall + SW'(1);
    end

    assign starve = (stall == SW'(STARVE_MAX));

    // Head outputs read as zero when the FIFO is empty
    assign head          = i_v ? mem[rd_ptr] : '0;
    assign {i_x, i_y, i_d} = head;

endmodule
